id_stage_ctrl: RTL

//   Sequences the instruction-decode stage of the MCU-32X pipeline.

---
 rtl/id_stage_ctrl_pkg.sv | 33 +++
 rtl/id_stage_ctrl_if.sv | 30 +++
 rtl/id_stage_ctrl_hazard.sv | 27 ++
 rtl/id_stage_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/id_stage_ctrl_pkg.sv
// Shared MCU-32X ISA constants and ID-stage state encoding.
package mcu32x_isa_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ID_EMPTY = 2'd0,
    ID_VALID = 2'd1,
    ID_STALL = 2'd2
  } id_state_e;

  function automatic logic uses_rs1(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_BRANCH, OPC_OP: uses_rs1 = 1'b1;
      default:                                            uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    case (opc)
      OPC_STORE, OPC_BRANCH, OPC_OP: uses_rs2 = 1'b1;
      default:                       uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_ctrl_if.sv
// Fetch -> ID -> EX handshake bundle seen by the decode-stage controller.
interface id_stage_ctrl_if;

  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        ex_ready;
  logic        ex_is_load;
  logic [4:0]  ex_rd;

  logic        flush;

  // Driven by fetch/EX/redirect side
  modport master (
    output if_valid, if_instr, if_pc, ex_ready, ex_is_load, ex_rd, flush,
    input  if_ready, id_valid, id_instr, id_pc
  );

  // Seen by the ID-stage controller
  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready, ex_is_load, ex_rd, flush,
    output if_ready, id_valid, id_instr, id_pc
  );

endinterface

// File: rtl/id_stage_ctrl_hazard.sv
// Load-use hazard detect for one instruction against the load in EX.
// Kept standalone so the forwarding unit can reuse it.
module id_hazard_unit
  import mcu32x_isa_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  output logic        hazard
);

  logic use1;
  logic use2;
  logic unused_instr_bits;

  assign unused_instr_bits = ^{instr[31:25], instr[14:7]};

  // Source-register decode and match; x0 never interlocks
  always_comb begin
    use1   = uses_rs1(instr[6:0]);
    use2   = uses_rs2(instr[6:0]);
    hazard = ex_is_load && (ex_rd != 5'd0) &&
             ((use1 && (instr[19:15] == ex_rd)) ||
              (use2 && (instr[24:20] == ex_rd)));
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// ID-stage sequencer: owns the IF/ID register, runs the fetch/EX handshake,
// interlocks load-use hazards and kills the slot on redirect.
//
// state    | meaning
// ---------+---------------------------------------------------
// ID_EMPTY | slot holds NOP, nothing to issue
// ID_VALID | slot full, instruction issuable to EX
// ID_STALL | slot full, held back by a load-use interlock
module id_stage_ctrl
  import mcu32x_isa_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mcu32x_isa_pkg::NOP_INSTR,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_stage_ctrl_if.slave   pipe,
  output logic             hazard,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  id_state_e   state_q;
  id_state_e   state_d;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  logic full;
  logic hz_held;
  logic hz_new;
  logic fire_out;
  logic accept;
  logic load_en;
  logic clear_en;

  // Held instruction checked against EX now; incoming one predicts next state
  id_hazard_unit u_hz_held (
    .instr      (instr_q),
    .ex_is_load (pipe.ex_is_load),
    .ex_rd      (pipe.ex_rd),
    .hazard     (hz_held)
  );

  id_hazard_unit u_hz_new (
    .instr      (pipe.if_instr),
    .ex_is_load (pipe.ex_is_load),
    .ex_rd      (pipe.ex_rd),
    .hazard     (hz_new)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ID_EMPTY;
    else     state_q <= state_d;
  end

  // Next state: flush > fetch load (incl. drain+fill) > drain > hold
  always_comb begin
    state_d  = state_q;
    load_en  = 1'b0;
    clear_en = 1'b0;
    if (pipe.flush) begin
      state_d  = ID_EMPTY;
      clear_en = 1'b1;
    end else if (accept) begin
      state_d  = hz_new ? ID_STALL : ID_VALID;
      load_en  = 1'b1;
    end else if (fire_out) begin
      state_d  = ID_EMPTY;
      clear_en = 1'b1;
    end else if (state_q != ID_EMPTY) begin
      state_d  = hz_held ? ID_STALL : ID_VALID;
    end
  end

  // Handshake outputs; reset forces the slot to look empty immediately
  always_comb begin
    full          = (state_q != ID_EMPTY) && !rst;
    hazard        = full && hz_held;
    pipe.id_valid = full && !hz_held;
    fire_out      = pipe.id_valid && pipe.ex_ready;
    pipe.if_ready = !full || fire_out || pipe.flush;
    accept        = pipe.if_valid && pipe.if_ready && !pipe.flush;
    pipe.id_instr = instr_q;
    pipe.id_pc    = pc_q;
  end

  // IF/ID register; an empty slot always carries NOP into decode
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
    end else if (load_en) begin
      instr_q <= pipe.if_instr;
      pc_q    <= pipe.if_pc;
    end else if (clear_en) begin
      instr_q <= NOP_INSTR;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_ONE;
      if (pipe.flush && full && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
